actor_motion_ctrl: RTL

ACTOR_MOTION_CTRL -- requirements
Module: actor_motion_ctrl

---
 rtl/pacman_pkg.sv | 32 +++
 rtl/tile_neighbor_lookup.sv | 64 ++++++
 rtl/actor_motion_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared definitions for the maze actors: direction codes, motion state
// encoding and the row-major tile index helper.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_MOVE = 1'b1
    } motion_state_t;

    function automatic int unsigned tile_index(input int unsigned col,
                                               input int unsigned row,
                                               input int unsigned cols);
        return row * cols + col;
    endfunction

    function automatic dir_t opposite_dir(input dir_t heading);
        case (heading)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/tile_neighbor_lookup.sv
// Combinational neighbour-wall lookup: given a tile and a heading, reports
// whether the adjacent tile is blocked. Grid edges count as walls; with
// ACTOR_TUNNEL_WRAP_EN defined the left/right edges wrap to the opposite
// column of the same row. Top/bottom edges are always walls.
module tile_neighbor_lookup
    import pacman_pkg::*;
#(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 24
) (
    input  logic [$clog2(COLS)-1:0] col,
    input  logic [$clog2(ROWS)-1:0] row,
    input  dir_t                    heading,
    input  logic [COLS*ROWS-1:0]    walls,
    output logic                    blocked
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned IW = $clog2(COLS*ROWS);

    logic [IW-1:0] idx;
    logic          edge_hit;

    // Resolve the neighbour index (or an edge hit) and look up its wall bit
    always_comb begin
        edge_hit = 1'b0;
        idx      = '0;
        case (heading)
            DIR_UP: begin
                if (row == '0) edge_hit = 1'b1;
                else idx = IW'(tile_index(32'(col), 32'(row) - 32'd1, COLS));
            end
            DIR_DOWN: begin
                if (row == RW'(ROWS-1)) edge_hit = 1'b1;
                else idx = IW'(tile_index(32'(col), 32'(row) + 32'd1, COLS));
            end
            DIR_LEFT: begin
                if (col == '0) begin
`ifdef ACTOR_TUNNEL_WRAP_EN
                    idx = IW'(tile_index(COLS - 1, 32'(row), COLS));
`else
                    edge_hit = 1'b1;
`endif
                end else begin
                    idx = IW'(tile_index(32'(col) - 32'd1, 32'(row), COLS));
                end
            end
            default: begin
                if (col == CW'(COLS-1)) begin
`ifdef ACTOR_TUNNEL_WRAP_EN
                    idx = IW'(tile_index(0, 32'(row), COLS));
`else
                    edge_hit = 1'b1;
`endif
                end else begin
                    idx = IW'(tile_index(32'(col) + 32'd1, 32'(row), COLS));
                end
            end
        endcase
        blocked = edge_hit | walls[idx];
    end

endmodule

// File: rtl/actor_motion_ctrl.sv
// Player actor motion controller: keyboard turn buffer, tile-grid movement
// at SPEED pixels per step, wall stops and dot detection.
// Optional build macro ACTOR_TUNNEL_WRAP_EN enables left/right edge wrap.
module actor_motion_ctrl
    import pacman_pkg::*;
#(
    parameter int unsigned TILE      = 20,
    parameter int unsigned COLS      = 32,
    parameter int unsigned ROWS      = 24,
    parameter int unsigned SPEED     = 4,
    parameter int unsigned STEP_DIV  = 4,
    parameter int unsigned START_COL = 1,
    parameter int unsigned START_ROW = 1,
    parameter int unsigned BUF_STEPS = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           w,
    input  logic                           a,
    input  logic                           s,
    input  logic                           d,
    input  logic [COLS*ROWS-1:0]           tilemap_walls,
    input  logic [COLS*ROWS-1:0]           tilemap_dots,
    output logic [$clog2(COLS*TILE)-1:0]   pos_x,
    output logic [$clog2(ROWS*TILE)-1:0]   pos_y,
    output logic [1:0]                     dir,
    output logic                           moving,
    output logic                           dot_eaten,
    output logic [$clog2(COLS*ROWS)-1:0]   dot_idx
);

    localparam int unsigned XW = $clog2(COLS*TILE);
    localparam int unsigned YW = $clog2(ROWS*TILE);
    localparam int unsigned IW = $clog2(COLS*ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned BW = $clog2(BUF_STEPS + 1);

    localparam logic [XW-1:0] TILE_X  = XW'(TILE);
    localparam logic [YW-1:0] TILE_Y  = YW'(TILE);
    localparam logic [XW-1:0] SPEED_X = XW'(SPEED);
    localparam logic [YW-1:0] SPEED_Y = YW'(SPEED);
    localparam logic [XW-1:0] X_START = XW'(START_COL * TILE);
    localparam logic [YW-1:0] Y_START = YW'(START_ROW * TILE);
`ifdef ACTOR_TUNNEL_WRAP_EN
    localparam logic [XW-1:0] X_LAST  = XW'((COLS - 1) * TILE);
`endif

    logic [DW-1:0]  div_cnt;
    logic           step;
    logic [3:0]     key_q;
    logic [3:0]     pressed;
    logic [3:0]     fresh;
    logic           key_hit;
    dir_t           key_dir;
    dir_t           buf_dir;
    logic [BW-1:0]  buf_cnt;
    logic           buf_valid;
    motion_state_t  state, state_nx;
    dir_t           dir_q;
    logic           aligned;
    logic [CW-1:0]  cur_col;
    logic [RW-1:0]  cur_row;
    logic           fwd_blocked;
    logic           turn_blocked;
    logic           turn_ok;
    logic           do_move;
    dir_t           mv_dir;
    logic [XW-1:0]  nx;
    logic [YW-1:0]  ny;
    logic           n_aligned;
    logic [IW-1:0]  n_idx;
    logic           dot_hit;

    assign step      = (div_cnt == DW'(STEP_DIV - 1));
    assign buf_valid = (buf_cnt != '0);
    assign aligned   = ((pos_x % TILE_X) == '0) && ((pos_y % TILE_Y) == '0);
    assign cur_col   = CW'(pos_x / TILE_X);
    assign cur_row   = RW'(pos_y / TILE_Y);
    assign dir       = dir_q;

    // Free-running step divider
    always_ff @(posedge clk) begin
        if (reset) div_cnt <= '0;
        else if (step) div_cnt <= '0;
        else div_cnt <= div_cnt + 1'b1;
    end

    // Detect newly pressed (active-low) keys, priority w > s > a > d
    always_comb begin
        pressed = {~w, ~s, ~a, ~d};
        fresh   = pressed & ~key_q;
        key_hit = |fresh;
        if (fresh[3])      key_dir = DIR_UP;
        else if (fresh[2]) key_dir = DIR_DOWN;
        else if (fresh[1]) key_dir = DIR_LEFT;
        else               key_dir = DIR_RIGHT;
    end

    // Turn buffer: a new press overwrites; otherwise age it on each step
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q   <= '0;
            buf_dir <= DIR_LEFT;
            buf_cnt <= '0;
        end else begin
            key_q <= pressed;
            if (key_hit) begin
                buf_dir <= key_dir;
                buf_cnt <= BW'(BUF_STEPS);
            end else if (step && buf_valid) begin
                if (turn_ok) buf_cnt <= '0;
                else buf_cnt <= buf_cnt - 1'b1;
            end
        end
    end

    tile_neighbor_lookup #(.COLS(COLS), .ROWS(ROWS)) u_fwd_lookup (
        .col     (cur_col),
        .row     (cur_row),
        .heading (dir_q),
        .walls   (tilemap_walls),
        .blocked (fwd_blocked)
    );

    tile_neighbor_lookup #(.COLS(COLS), .ROWS(ROWS)) u_turn_lookup (
        .col     (cur_col),
        .row     (cur_row),
        .heading (buf_dir),
        .walls   (tilemap_walls),
        .blocked (turn_blocked)
    );

    // Motion state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_STOP;
        else state <= state_nx;
    end

    // Step decision: buffered turn first, then forward motion or stop.
    // Aligned turns (including reversals) need an open target tile; between
    // tiles only a reversal is possible, since both tiles are known open.
    always_comb begin
        state_nx = state;
        do_move  = 1'b0;
        mv_dir   = dir_q;
        turn_ok  = 1'b0;
        moving   = (state == ST_MOVE);
        if (step) begin
            if (buf_valid) begin
                if (aligned) turn_ok = !turn_blocked && ((state == ST_STOP) || (buf_dir != dir_q));
                else turn_ok = (buf_dir == opposite_dir(dir_q));
            end
            if (turn_ok) begin
                state_nx = ST_MOVE;
                do_move  = 1'b1;
                mv_dir   = buf_dir;
            end else if (state == ST_MOVE) begin
                if (aligned && fwd_blocked) state_nx = ST_STOP;
                else do_move = 1'b1;
            end
        end
    end

    // Next position for this step
    always_comb begin
        nx = pos_x;
        ny = pos_y;
        if (do_move) begin
            case (mv_dir)
                DIR_UP:   ny = pos_y - SPEED_Y;
                DIR_DOWN: ny = pos_y + SPEED_Y;
                DIR_LEFT: begin
`ifdef ACTOR_TUNNEL_WRAP_EN
                    if (pos_x == '0) nx = X_LAST;
                    else nx = pos_x - SPEED_X;
`else
                    nx = pos_x - SPEED_X;
`endif
                end
                default: begin
`ifdef ACTOR_TUNNEL_WRAP_EN
                    if (pos_x == X_LAST) nx = '0;
                    else nx = pos_x + SPEED_X;
`else
                    nx = pos_x + SPEED_X;
`endif
                end
            endcase
        end
        n_aligned = ((nx % TILE_X) == '0) && ((ny % TILE_Y) == '0);
        n_idx     = IW'(tile_index(32'(nx / TILE_X), 32'(ny / TILE_Y), COLS));
        dot_hit   = do_move && n_aligned && tilemap_dots[n_idx];
    end

    // Position and heading registers (nx/ny equal pos when not stepping)
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x <= X_START;
            pos_y <= Y_START;
            dir_q <= DIR_LEFT;
        end else begin
            pos_x <= nx;
            pos_y <= ny;
            if (turn_ok) dir_q <= buf_dir;
        end
    end

    // Dot pulse, raised for the cycle following a landing on a dotted tile
    always_ff @(posedge clk) begin
        if (reset) begin
            dot_eaten <= 1'b0;
            dot_idx   <= '0;
        end else begin
            dot_eaten <= dot_hit;
            if (dot_hit) dot_idx <= n_idx;
        end
    end

endmodule
